sdram_boot_sequencer: RTL and testbench



---
 rtl/sdram_boot_sequencer.sv | 125 ++++++++++++
 tb/tb_sdram_boot_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_boot_sequencer.sv
// SDRAM power-up sequencer: drives CKE, precharge-all, init auto-refreshes and
// load-mode, then releases the bus and generates the periodic refresh tick.
module sdram_boot_sequencer #(
  parameter logic [12:0] MODE           = 13'h0022,
  parameter int unsigned CKE_LOW_CYCLES = 100,
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned TRP_CYCLES     = 2,
  parameter int unsigned TRFC_CYCLES    = 7,
  parameter int unsigned TMRD_CYCLES    = 2,
  parameter int unsigned INIT_REFRESHES = 8,
  parameter int unsigned REFRESH_PERIOD = 390,
  parameter int unsigned REFRESH_PULSE  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        CLKE,
  output logic [3:0]  CMD,
  output logic [12:0] ARAM,
  output logic        READY,
  output logic        REFRESH
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  localparam logic [12:0] ARAM_ALL_BANKS = 13'h0400;

  localparam logic [15:0] CKE_C   = 16'(CKE_LOW_CYCLES);
  localparam logic [15:0] PU_C    = 16'(POWERUP_CYCLES);
  localparam logic [15:0] TRP_C   = 16'(TRP_CYCLES);
  localparam logic [15:0] TRFC_C  = 16'(TRFC_CYCLES);
  localparam logic [15:0] TMRD_C  = 16'(TMRD_CYCLES);
  localparam logic [15:0] NREF_C  = 16'(INIT_REFRESHES);
  localparam logic [15:0] PER_C   = 16'(REFRESH_PERIOD);
  localparam logic [15:0] PULSE_C = 16'(REFRESH_PULSE);

  typedef enum logic [2:0] {
    PWR,
    PRE,
    REF,
    MRS,
    RUN
  } state_t;

  state_t      state;
  logic [15:0] tmr;
  logic [15:0] ref_cnt;
  logic [15:0] rtmr;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= PWR;
      tmr     <= '0;
      ref_cnt <= '0;
      rtmr    <= '0;
      CLKE    <= 1'b0;
      CMD     <= CMD_NOP;
      ARAM    <= '0;
      READY   <= 1'b1;
      REFRESH <= 1'b0;
    end else begin
      // commands last exactly one cycle; any command edge overrides this
      CMD <= CMD_NOP;
      case (state)
        PWR: begin
          tmr <= tmr + 16'd1;
          if (tmr == CKE_C) CLKE <= 1'b1;
          if (tmr == PU_C) begin
            CMD   <= CMD_PRE;
            ARAM  <= ARAM_ALL_BANKS;
            tmr   <= 16'd1;
            state <= PRE;
          end
        end
        PRE: begin
          if (tmr == TRP_C) begin
            CMD     <= CMD_AREF;
            ARAM    <= '0;
            ref_cnt <= 16'd1;
            tmr     <= 16'd1;
            state   <= REF;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        REF: begin
          if (tmr == TRFC_C) begin
            tmr <= 16'd1;
            if (ref_cnt == NREF_C) begin
              CMD   <= CMD_LMR;
              ARAM  <= MODE;
              state <= MRS;
            end else begin
              CMD     <= CMD_AREF;
              ref_cnt <= ref_cnt + 16'd1;
            end
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        MRS: begin
          if (tmr == TMRD_C) begin
            READY <= 1'b0;
            ARAM  <= '0;
            rtmr  <= 16'd1;
            tmr   <= '0;
            state <= RUN;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        RUN: begin
          // rtmr wraps back to 1 on the tick edge so the period never drifts
          if (rtmr == PER_C) rtmr <= 16'd1;
          else               rtmr <= rtmr + 16'd1;
          REFRESH <= (rtmr == PER_C) || (REFRESH && (rtmr < PULSE_C));
        end
        default: state <= PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_boot_sequencer.sv
// Bench for sdram_boot_sequencer: two instances (2 and 1 init refreshes) compared
// every edge against a timeline model computed from edge index since reset release.
module tb_sdram_boot_sequencer;

  localparam int PU   = 20;
  localparam int CKEL = 5;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TMRD = 2;
  localparam int PER  = 50;
  localparam int PW   = 4;
  localparam logic [12:0] MODE_V = 13'h0022;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PREC = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        clke_a, ready_a, refresh_a;
  logic [3:0]  cmd_a;
  logic [12:0] aram_a;
  logic        clke_b, ready_b, refresh_b;
  logic [3:0]  cmd_b;
  logic [12:0] aram_b;

  int total = 0;
  int bad   = 0;
  int k     = -1;

  typedef struct packed {
    logic        clke;
    logic [3:0]  cmd;
    logic        aram_chk;
    logic [12:0] aram;
    logic        ready;
    logic        refresh;
  } exp_t;

  exp_t ea, eb;

  always #5 CLK = ~CLK;

  sdram_boot_sequencer #(
    .MODE(MODE_V), .CKE_LOW_CYCLES(CKEL), .POWERUP_CYCLES(PU), .TRP_CYCLES(TRP),
    .TRFC_CYCLES(TRFC), .TMRD_CYCLES(TMRD), .INIT_REFRESHES(2),
    .REFRESH_PERIOD(PER), .REFRESH_PULSE(PW)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .CLKE(clke_a), .CMD(cmd_a), .ARAM(aram_a),
    .READY(ready_a), .REFRESH(refresh_a)
  );

  sdram_boot_sequencer #(
    .MODE(MODE_V), .CKE_LOW_CYCLES(CKEL), .POWERUP_CYCLES(PU), .TRP_CYCLES(TRP),
    .TRFC_CYCLES(TRFC), .TMRD_CYCLES(TMRD), .INIT_REFRESHES(1),
    .REFRESH_PERIOD(PER), .REFRESH_PULSE(PW)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .CLKE(clke_b), .CMD(cmd_b), .ARAM(aram_b),
    .READY(ready_b), .REFRESH(refresh_b)
  );

  // Expected outputs after edge kk (kk < 0: the edge sampled RESET=0).
  function automatic exp_t model(input int kk, input int nref);
    exp_t e;
    int lm, fall, d;
    e = '{clke: 1'b0, cmd: NOP, aram_chk: 1'b1, aram: 13'h0, ready: 1'b1, refresh: 1'b0};
    if (kk < 0) return e;
    lm   = PU + TRP + nref * TRFC;
    fall = lm + TMRD;
    e.clke = (kk >= CKEL);
    if (kk == PU) begin
      e.cmd  = PREC;
      e.aram = 13'h0400;
    end else if (kk == lm) begin
      e.cmd  = LMR;
      e.aram = MODE_V;
    end else if (kk > PU && kk < fall) begin
      e.aram_chk = 1'b0;
      d = kk - PU - TRP;
      if (d >= 0 && kk < lm && (d % TRFC) == 0) e.cmd = AREF;
    end
    e.ready = (kk < fall);
    d = kk - fall;
    e.refresh = (d >= PER) && ((d % PER) < PW);
    return e;
  endfunction

  task automatic step(input logic r);
    RESET = r;
    @(posedge CLK);
    #1;
    if (!r) k = -1;
    else    k++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      ea = model(k, 2);
      total++;
      if ({clke_a, cmd_a, aram_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh}) begin
        bad++;
        $display("FAIL reset_a got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", clke_a, cmd_a, aram_a, ready_a, refresh_a,
                 ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
      end
      total++;
      if ({clke_b, cmd_b, aram_b, ready_b, refresh_b} !== {ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh}) begin
        bad++;
        $display("FAIL reset_b got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", clke_b, cmd_b, aram_b, ready_b, refresh_b,
                 ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
      end
    end
  endtask

  task automatic test_init_timeline;
    while (k < 45) begin
      step(1'b1);
      ea = model(k, 2);
      total++;
      if ({clke_a, cmd_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.ready, ea.refresh} ||
          (ea.aram_chk && aram_a !== ea.aram)) begin
        bad++;
        $display("FAIL init_a k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, clke_a, cmd_a, aram_a, ready_a,
                 refresh_a, ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
      end
    end
  endtask

  task automatic test_refresh_pulses;
    int highs;
    highs = 0;
    while (k < 199) begin
      step(1'b1);
      ea = model(k, 2);
      if (refresh_a === 1'b1) highs++;
      total++;
      if ({clke_a, cmd_a, aram_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh}) begin
        bad++;
        $display("FAIL refresh_a k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, clke_a, cmd_a, aram_a, ready_a,
                 refresh_a, ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
      end
    end
    total++;
    if (highs !== 3 * PW) begin
      bad++;
      $display("FAIL refresh_high_count got %0d want %0d", highs, 3 * PW);
    end
  endtask

  task automatic test_reset_at(input string tag, input int at, input int run_to);
    step(1'b0);
    while (k < at - 1) step(1'b1);
    step(1'b0);
    ea = model(k, 2);
    total++;
    if ({clke_a, cmd_a, aram_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh}) begin
      bad++;
      $display("FAIL %s_hit got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", tag, clke_a, cmd_a, aram_a, ready_a,
               refresh_a, ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
    end
    while (k < run_to) begin
      step(1'b1);
      ea = model(k, 2);
      total++;
      if ({clke_a, cmd_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.ready, ea.refresh} ||
          (ea.aram_chk && aram_a !== ea.aram)) begin
        bad++;
        $display("FAIL %s k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", tag, k, clke_a, cmd_a, aram_a, ready_a,
                 refresh_a, ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
      end
    end
  endtask

  task automatic test_single_refresh;
    int arefs, lm_at, fall_at;
    arefs = 0; lm_at = -1; fall_at = -1;
    step(1'b0);
    while (k < 60) begin
      step(1'b1);
      eb = model(k, 1);
      if (cmd_b === AREF) arefs++;
      if (cmd_b === LMR) lm_at = k;
      if (ready_b === 1'b0 && fall_at < 0) fall_at = k;
      total++;
      if ({clke_b, cmd_b, ready_b, refresh_b} !== {eb.clke, eb.cmd, eb.ready, eb.refresh} ||
          (eb.aram_chk && aram_b !== eb.aram)) begin
        bad++;
        $display("FAIL single_b k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, clke_b, cmd_b, aram_b, ready_b,
                 refresh_b, eb.clke, eb.cmd, eb.aram, eb.ready, eb.refresh);
      end
    end
    total++;
    if (arefs !== 1) begin bad++; $display("FAIL single_aref_count got %0d want 1", arefs); end
    total++;
    if (lm_at !== 29) begin bad++; $display("FAIL single_lmr_edge got %0d want 29", lm_at); end
    total++;
    if (fall_at !== 31) begin bad++; $display("FAIL single_ready_fall got %0d want 31", fall_at); end
  endtask

  task automatic test_random_resets;
    int run_len, hold;
    for (int it = 0; it < 10; it++) begin
      run_len = int'($urandom_range(1, 150));
      hold    = int'($urandom_range(1, 3));
      for (int j = 0; j < run_len + hold; j++) begin
        step(j < run_len ? 1'b1 : 1'b0);
        ea = model(k, 2);
        eb = model(k, 1);
        total++;
        if ({clke_a, cmd_a, ready_a, refresh_a} !== {ea.clke, ea.cmd, ea.ready, ea.refresh} ||
            (ea.aram_chk && aram_a !== ea.aram)) begin
          bad++;
          $display("FAIL random_a k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, clke_a, cmd_a, aram_a, ready_a,
                   refresh_a, ea.clke, ea.cmd, ea.aram, ea.ready, ea.refresh);
        end
        total++;
        if ({clke_b, cmd_b, ready_b, refresh_b} !== {eb.clke, eb.cmd, eb.ready, eb.refresh} ||
            (eb.aram_chk && aram_b !== eb.aram)) begin
          bad++;
          $display("FAIL random_b k=%0d got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b", k, clke_b, cmd_b, aram_b, ready_b,
                   refresh_b, eb.clke, eb.cmd, eb.aram, eb.ready, eb.refresh);
        end
      end
    end
  endtask

  task automatic test_long_run;
    int last_rise, rises;
    logic prev;
    last_rise = -1; rises = 0; prev = 1'b0;
    step(1'b0);
    while (k < 38) step(1'b1);
    while (k < 38 + 10000) begin
      step(1'b1);
      total++;
      if ({clke_a, cmd_a, aram_a, ready_a} !== {1'b1, NOP, 13'h0, 1'b0}) begin
        bad++;
        $display("FAIL long_static k=%0d got %b/%b/%h/%b want 1/0111/0000/0", k, clke_a, cmd_a, aram_a, ready_a);
      end
      if (refresh_a === 1'b1 && prev === 1'b0) begin
        rises++;
        if (last_rise >= 0) begin
          total++;
          if (k - last_rise !== PER) begin
            bad++;
            $display("FAIL long_spacing k=%0d got %0d want %0d", k, k - last_rise, PER);
          end
        end
        last_rise = k;
      end
      prev = refresh_a;
    end
    total++;
    if (rises !== 200) begin bad++; $display("FAIL long_rise_count got %0d want 200", rises); end
  endtask

  initial begin
    test_reset;
    test_init_timeline;
    test_refresh_pulses;
    test_reset_at("reset_mid_init", 27, 100);
    test_reset_at("reset_mid_pulse", 89, 150);
    test_single_refresh;
    test_random_resets;
    test_long_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
